// File: rtl/c4_pkg.sv
// c4_pkg: shared Connect-4 board dimensions, board type and turn FSM states
package c4_pkg;
  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int CELLS = ROWS * COLS;
  localparam int HW = $clog2(ROWS + 1);
  localparam int MW = $clog2(CELLS + 1);
  typedef logic [ROWS-1:0][COLS-1:0] board_t;
  typedef enum logic [1:0] {IDLE, CHECK, EVAL, OVER} state_t;
endpackage

// File: rtl/c4_column_heights.sv
// c4_column_heights: per-column fill counters with full flags, clear and increment-on-select
module c4_column_heights
  import c4_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     inc_i,
  input  logic [2:0]               sel_i,
  output logic [COLS-1:0][HW-1:0]  height_o,
  output logic [COLS-1:0]          full_o
);
  logic [COLS-1:0][HW-1:0] h_q, h_d;
  always_comb begin
    h_d = h_q;
    full_o = '0;
    for (int c = 0; c < COLS; c++) begin
      h_d[c] = h_q[c] + HW'(inc_i && sel_i == 3'(c));
      full_o[c] = h_q[c] == HW'(ROWS);
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clear_i) h_q <= '0;
    else h_q <= h_d;
  end
  assign height_o = h_q;
endmodule

// File: rtl/game_turn_controller.sv
// game_turn_controller: Connect-4 turn sequencer owning boards, heights, player and move count
module game_turn_controller
  import c4_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       newGame,
  input  logic                       dropValid,
  input  logic [2:0]                 dropCol,
  input  logic                       weHaveAWinner,
  output logic                       ready,
  output logic                       moveAccept,
  output logic                       moveReject,
  output logic [ROWS-1:0][COLS-1:0]  board0,
  output logic [ROWS-1:0][COLS-1:0]  board1,
  output logic                       currentPlayer,
  output logic                       winEnable,
  output logic                       gameOver,
  output logic                       winner,
  output logic                       draw
);
  state_t state_q, state_d;
  board_t b0_q, b0_d, b1_q, b1_d, place;
  logic [MW-1:0] cnt_q, cnt_d;
  logic cur_q, cur_d, win_q, win_d, draw_q, draw_d, acc_q, rej_q, acc, rej, sel_full;
  logic [COLS-1:0][HW-1:0] heights;
  logic [COLS-1:0] full;
  logic [HW-1:0] h_sel;

  c4_column_heights u_heights (
    .clk      (clk),
    .rst      (reset),
    .clear_i  (newGame),
    .inc_i    (acc),
    .sel_i    (dropCol),
    .height_o (heights),
    .full_o   (full)
  );

  // an out-of-range column never matches, so it reads as full and is rejected
  always_comb begin
    h_sel = '0;
    sel_full = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (dropCol == 3'(c)) begin
        h_sel = heights[c];
        sel_full = full[c];
      end
  end

  assign acc = state_q == IDLE && dropValid && !sel_full;
  assign rej = state_q == IDLE && dropValid && sel_full;
  assign place = board_t'(1) << (int'(h_sel) * COLS + int'(dropCol));

  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    b0_d = b0_q;
    b1_d = b1_q;
    cnt_d = cnt_q;
    win_d = win_q;
    draw_d = draw_q;
    case (state_q)
      IDLE: if (acc) begin
        state_d = CHECK;
        b0_d = cur_q ? b0_q : b0_q | place;
        b1_d = cur_q ? b1_q | place : b1_q;
        cnt_d = cnt_q + MW'(1);
      end
      CHECK: state_d = EVAL;
      EVAL: begin
        state_d = (weHaveAWinner || cnt_q == MW'(CELLS)) ? OVER : IDLE;
        win_d = weHaveAWinner & cur_q;
        draw_d = !weHaveAWinner && cnt_q == MW'(CELLS);
        cur_d = (weHaveAWinner || cnt_q == MW'(CELLS)) ? cur_q : !cur_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || newGame) begin
      state_q <= IDLE;
      cur_q <= 1'b0;
      b0_q <= '0;
      b1_q <= '0;
      cnt_q <= '0;
      win_q <= 1'b0;
      draw_q <= 1'b0;
      acc_q <= 1'b0;
      rej_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
      cnt_q <= cnt_d;
      win_q <= win_d;
      draw_q <= draw_d;
      acc_q <= acc;
      rej_q <= rej;
    end
  end

  assign ready = state_q == IDLE;
  assign winEnable = state_q == CHECK;
  assign gameOver = state_q == OVER;
  assign moveAccept = acc_q;
  assign moveReject = rej_q;
  assign board0 = b0_q;
  assign board1 = b1_q;
  assign currentPlayer = cur_q;
  assign winner = win_q;
  assign draw = draw_q;
endmodule

// File: tb/tb_game_turn_controller.sv
// tb_game_turn_controller: directed checks of the turn sequencer against a behavioural win checker
module tb_game_turn_controller;
  import c4_pkg::*;
  logic clk = 1'b0, reset, newGame, dropValid, weHaveAWinner;
  logic [2:0] dropCol;
  logic ready, moveAccept, moveReject, currentPlayer, winEnable, gameOver, winner, draw;
  board_t board0, board1;
  logic chk_p;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  game_turn_controller dut (
    .clk(clk), .reset(reset), .newGame(newGame), .dropValid(dropValid), .dropCol(dropCol),
    .weHaveAWinner(weHaveAWinner), .ready(ready), .moveAccept(moveAccept), .moveReject(moveReject),
    .board0(board0), .board1(board1), .currentPlayer(currentPlayer), .winEnable(winEnable),
    .gameOver(gameOver), .winner(winner), .draw(draw)
  );

  function automatic logic has_four(input board_t b);
    logic f = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c <= COLS - 4; c++)
        if (b[r][c] && b[r][c+1] && b[r][c+2] && b[r][c+3]) f = 1'b1;
    for (int r = 0; r <= ROWS - 4; r++)
      for (int c = 0; c < COLS; c++) begin
        if (b[r][c] && b[r+1][c] && b[r+2][c] && b[r+3][c]) f = 1'b1;
        if (c <= COLS - 4 && b[r][c] && b[r+1][c+1] && b[r+2][c+2] && b[r+3][c+3]) f = 1'b1;
        if (c >= 3 && b[r][c] && b[r+1][c-1] && b[r+2][c-2] && b[r+3][c-3]) f = 1'b1;
      end
    return f;
  endfunction

  // registered win checker: one cycle of latency after winEnable
  always @(posedge clk) begin
    if (reset) weHaveAWinner <= 1'b0;
    else weHaveAWinner <= winEnable && has_four(currentPlayer ? board1 : board0);
    if (winEnable) chk_p <= currentPlayer;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic new_game;
    newGame = 1'b1;
    tick;
    newGame = 1'b0;
  endtask

  task automatic move(input logic [2:0] col, output logic a, output logic r, output int we);
    dropCol = col;
    dropValid = 1'b1;
    tick;
    dropValid = 1'b0;
    a = moveAccept;
    r = moveReject;
    we = int'(winEnable);
    if (a) begin
      tick;
      we += int'(winEnable);
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b exp 1", ready); end
    tests++; if ({moveAccept, moveReject, winEnable, gameOver, draw, winner, currentPlayer} !== 7'b0) begin
      fails++; $display("FAIL reset_flags: got %b exp 0000000", {moveAccept, moveReject, winEnable, gameOver, draw, winner, currentPlayer}); end
    tests++; if ((board0 | board1) !== '0) begin fails++; $display("FAIL reset_boards: got %h/%h exp 0", board0, board1); end
  endtask

  task automatic test_horizontal_win;
    logic [2:0] cols [7] = '{0, 0, 1, 1, 2, 2, 3};
    logic a, r;
    int we, n_acc = 0, n_we = 0;
    for (int i = 0; i < 7; i++) begin
      move(cols[i], a, r, we);
      n_acc += int'(a);
      n_we += we;
      if (i == 0) begin
        tests++; if (currentPlayer !== 1'b1) begin fails++; $display("FAIL hwin_toggle: got %b exp 1", currentPlayer); end
      end
    end
    tests++; if (n_acc !== 7) begin fails++; $display("FAIL hwin_accepts: got %0d exp 7", n_acc); end
    tests++; if (n_we !== 7) begin fails++; $display("FAIL hwin_winen_cycles: got %0d exp 7", n_we); end
    tests++; if ({gameOver, winner, draw, ready} !== 4'b1000) begin
      fails++; $display("FAIL hwin_result: got over/win/draw/ready=%b exp 1000", {gameOver, winner, draw, ready}); end
    tests++; if (board0[0][3:0] !== 4'b1111) begin fails++; $display("FAIL hwin_board0: got %b exp 1111", board0[0][3:0]); end
    tests++; if (board1[1][2:0] !== 3'b111) begin fails++; $display("FAIL hwin_board1: got %b exp 111", board1[1][2:0]); end
    move(3'd5, a, r, we);
    tests++; if ({a, r, gameOver} !== 3'b001) begin fails++; $display("FAIL over_ignores_drop: got acc/rej/over=%b exp 001", {a, r, gameOver}); end
  endtask

  task automatic test_full_column;
    logic a, r;
    int we;
    board_t e0 = '0, e1 = '0;
    new_game;
    for (int i = 0; i < ROWS; i++) begin
      move(3'd4, a, r, we);
      if (i % 2 == 0) e0[i][4] = 1'b1;
      else e1[i][4] = 1'b1;
    end
    tests++; if ({board0, board1} !== {e0, e1}) begin fails++; $display("FAIL col4_fill: got %h/%h exp %h/%h", board0, board1, e0, e1); end
    move(3'd4, a, r, we);
    tests++; if ({a, r} !== 2'b01) begin fails++; $display("FAIL full_reject: got acc/rej=%b exp 01", {a, r}); end
    tests++; if ({ready, currentPlayer} !== 2'b10) begin fails++; $display("FAIL full_state: got ready/player=%b exp 10", {ready, currentPlayer}); end
    tests++; if ({board0, board1} !== {e0, e1}) begin fails++; $display("FAIL full_board_kept: got %h/%h exp %h/%h", board0, board1, e0, e1); end
    tick;
    tests++; if (moveReject !== 1'b0) begin fails++; $display("FAIL reject_pulse_width: got %b exp 0", moveReject); end
    move(3'd5, a, r, we);
    tests++; if ({a, board0[0][5]} !== 2'b11) begin fails++; $display("FAIL after_reject_p0: got acc/cell=%b exp 11", {a, board0[0][5]}); end
  endtask

  task automatic test_out_of_range;
    logic a, r;
    int we;
    new_game;
    move(3'd7, a, r, we);
    tests++; if ({a, r, ready} !== 3'b011) begin fails++; $display("FAIL col7_reject: got acc/rej/ready=%b exp 011", {a, r, ready}); end
    dropCol = 3'd0;
    dropValid = 1'b1;
    tick;
    tests++; if ({moveAccept, winEnable, ready} !== 3'b110) begin
      fails++; $display("FAIL hold_check: got acc/winen/ready=%b exp 110", {moveAccept, winEnable, ready}); end
    tick;
    tests++; if ({moveAccept, moveReject, winEnable, ready} !== 4'b0000) begin
      fails++; $display("FAIL hold_eval: got acc/rej/winen/ready=%b exp 0000", {moveAccept, moveReject, winEnable, ready}); end
    dropValid = 1'b0;
    tick;
    tests++; if ({moveAccept, moveReject, ready} !== 3'b001) begin fails++; $display("FAIL hold_idle: got acc/rej/ready=%b exp 001", {moveAccept, moveReject, ready}); end
    tests++; if ($countones(board0 | board1) !== 1 || board0[0][0] !== 1'b1) begin
      fails++; $display("FAIL hold_single_piece: got %h/%h exp one piece at [0][0]", board0, board1); end
  endtask

  task automatic test_draw;
    int s [7] = '{0, 0, 1, 1, 0, 0, 1};
    logic [2:0] seq [$];
    board_t e0;
    logic a, r;
    int we, n_acc = 0;
    new_game;
    for (int i = 0; i < 6; i++) seq.push_back(3'd0);
    for (int i = 0; i < 6; i++) seq.push_back(3'd1);
    seq.push_back(3'd4);
    for (int i = 0; i < 6; i++) seq.push_back(3'd2);
    for (int i = 0; i < 6; i++) seq.push_back(3'd3);
    for (int i = 0; i < 5; i++) seq.push_back(3'd4);
    seq.push_back(3'd5);
    for (int i = 0; i < 6; i++) seq.push_back(3'd6);
    for (int i = 0; i < 5; i++) seq.push_back(3'd5);
    for (int r2 = 0; r2 < ROWS; r2++)
      for (int c = 0; c < COLS; c++) e0[r2][c] = ((r2 + s[c]) % 2) == 0;
    for (int i = 0; i < 41; i++) begin
      move(seq[i], a, r, we);
      n_acc += int'(a);
    end
    tests++; if ({n_acc, ready, gameOver} !== {32'd41, 2'b10}) begin
      fails++; $display("FAIL draw_move41: got acc=%0d ready/over=%b exp 41 10", n_acc, {ready, gameOver}); end
    move(seq[41], a, r, we);
    tests++; if ({a, draw, gameOver, winner, ready} !== 5'b11100) begin
      fails++; $display("FAIL draw_result: got acc/draw/over/win/ready=%b exp 11100", {a, draw, gameOver, winner, ready}); end
    tests++; if (board0 !== e0 || board1 !== ~e0) begin fails++; $display("FAIL draw_board: got %h/%h exp %h/%h", board0, board1, e0, ~e0); end
    move(3'd0, a, r, we);
    tick;
    tick;
    tests++; if ({a, r, ready, draw} !== 4'b0001) begin fails++; $display("FAIL draw_hold: got acc/rej/ready/draw=%b exp 0001", {a, r, ready, draw}); end
    new_game;
    tests++; if ({draw, gameOver, ready} !== 3'b001) begin fails++; $display("FAIL draw_newgame: got draw/over/ready=%b exp 001", {draw, gameOver, ready}); end
  endtask

  task automatic test_clear_midturn;
    logic a, r;
    int we;
    move(3'd2, a, r, we);
    dropCol = 3'd0;
    dropValid = 1'b1;
    tick;
    dropValid = 1'b0;
    newGame = 1'b1;
    tick;
    newGame = 1'b0;
    tests++; if ({ready, winEnable, currentPlayer, moveAccept} !== 4'b1000 || (board0 | board1) !== '0) begin
      fails++; $display("FAIL newgame_in_check: got ready/winen/player/acc=%b boards %h/%h exp 1000 and 0", {ready, winEnable, currentPlayer, moveAccept}, board0, board1); end
    move(3'd2, a, r, we);
    tests++; if ({board0[0][2], currentPlayer} !== 2'b11) begin fails++; $display("FAIL newgame_heights: got cell/player=%b exp 11", {board0[0][2], currentPlayer}); end
    dropCol = 3'd1;
    dropValid = 1'b1;
    tick;
    dropValid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tests++; if ({ready, winEnable, currentPlayer, moveAccept} !== 4'b1000 || (board0 | board1) !== '0) begin
      fails++; $display("FAIL reset_in_check: got ready/winen/player/acc=%b boards %h/%h exp 1000 and 0", {ready, winEnable, currentPlayer, moveAccept}, board0, board1); end
    dropCol = 3'd3;
    dropValid = 1'b1;
    newGame = 1'b1;
    tick;
    dropValid = 1'b0;
    newGame = 1'b0;
    tests++; if ({moveAccept, ready} !== 2'b01 || (board0 | board1) !== '0) begin
      fails++; $display("FAIL newgame_over_drop: got acc/ready=%b boards %h/%h exp 01 and 0", {moveAccept, ready}, board0, board1); end
  endtask

  task automatic test_vertical_p1;
    logic [2:0] cols [8] = '{0, 6, 0, 6, 1, 6, 1, 6};
    logic a, r;
    int we;
    new_game;
    for (int i = 0; i < 8; i++) move(cols[i], a, r, we);
    tests++; if ({gameOver, winner, draw, currentPlayer} !== 4'b1101) begin
      fails++; $display("FAIL vwin_result: got over/win/draw/player=%b exp 1101", {gameOver, winner, draw, currentPlayer}); end
    tests++; if (chk_p !== 1'b1) begin fails++; $display("FAIL vwin_checked_player: got %b exp 1", chk_p); end
    tests++; if ({board1[3][6], board1[2][6], board1[1][6], board1[0][6], board1[4][6]} !== 5'b11110) begin
      fails++; $display("FAIL vwin_board1: got %b exp 11110", {board1[3][6], board1[2][6], board1[1][6], board1[0][6], board1[4][6]}); end
  endtask

  initial begin
    reset = 1'b1;
    newGame = 1'b0;
    dropValid = 1'b0;
    dropCol = 3'd0;
    test_reset;
    test_horizontal_win;
    test_full_column;
    test_out_of_range;
    test_draw;
    test_clear_midturn;
    test_vertical_p1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
